fib_stream_gen: RTL and testbench

- Parametrised, streaming Fibonacci-type sequence generator.
- Produces a programmable number of terms of the recurrence t(k+2) = t(k) + t(k+1), starting from runtime-loadable seeds (0,1 gives Fibonacci; 2,1 gives Lucas).
- Terms are emitted on a valid/ready stream with index and last markers.
- Wrap-around overflow is detected; the run either continues or halts early.
- Sits as a test-pattern/sequence source feeding downstream datapath blocks in the design.

---
 rtl/fib_stream_gen_if.sv | 28 ++
 rtl/fib_stream_gen.sv | 139 +++++++++++++
 tb/tb_fib_stream_gen.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fib_stream_gen_if.sv
// Output stream of the Fibonacci-type generator: one term per valid/ready beat,
// tagged with its 0-based index and an end-of-run marker.
interface fib_stream_gen_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_index;
  logic             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/fib_stream_gen.sv
// Streaming generator for t(k+2) = t(k) + t(k+1) from loadable seeds, with
// wrap-around detection that either flags the run or ends it before a wrapped term.
module fib_stream_gen #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    seed0,
  input  logic [WIDTH-1:0]    seed1,
  input  logic [CNT_W-1:0]    num_terms,
  input  logic                halt_on_ovf,
  fib_stream_gen_if.master    out_if,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic             prev_ovf_q, prev_ovf_d;
  logic             cur_ovf_q, cur_ovf_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic             halt_q, halt_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum_s;
  logic             run_s;
  logic             cnt_last_s;
  logic             last_s;

  assign sum_s      = {1'b0, prev_q} + {1'b0, cur_q};
  assign run_s      = (state_q == ST_RUN);
  assign cnt_last_s = (idx_q == (num_q - ONE_C));
  // In halt mode the run ends on the beat whose successor would be a wrapped term.
  assign last_s     = run_s && (cnt_last_s || (halt_q && cur_ovf_q));

  assign out_if.out_valid = run_s;
  assign out_if.out_data  = prev_q;
  assign out_if.out_index = idx_q;
  assign out_if.out_last  = last_s;
  assign busy             = run_s;
  assign done             = (state_q == ST_DONE);
  assign overflow         = ovf_q;

  // Next-state and datapath update for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    cur_d      = cur_q;
    prev_ovf_d = prev_ovf_q;
    cur_ovf_d  = cur_ovf_q;
    idx_d      = idx_q;
    num_d      = num_q;
    halt_d     = halt_q;
    ovf_d      = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          prev_d     = seed0;
          cur_d      = seed1;
          prev_ovf_d = 1'b0;
          cur_ovf_d  = 1'b0;
          idx_d      = ZERO_C;
          num_d      = num_terms;
          halt_d     = halt_on_ovf;
          ovf_d      = 1'b0;
          state_d    = (num_terms == ZERO_C) ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (out_if.out_ready) begin
          prev_d     = cur_q;
          prev_ovf_d = cur_ovf_q;
          cur_d      = sum_s[WIDTH-1:0];
          cur_ovf_d  = sum_s[WIDTH];
          idx_d      = idx_q + ONE_C;
          // Flag only when a wrapped term was emitted, or the run was cut short by one.
          if (prev_ovf_q && !halt_q) begin
            ovf_d = 1'b1;
          end else if (halt_q && cur_ovf_q && !cnt_last_s) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          state_d = last_s ? ST_DONE : ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      prev_q     <= {WIDTH{1'b0}};
      cur_q      <= {WIDTH{1'b0}};
      prev_ovf_q <= 1'b0;
      cur_ovf_q  <= 1'b0;
      idx_q      <= ZERO_C;
      num_q      <= ZERO_C;
      halt_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cur_q      <= cur_d;
      prev_ovf_q <= prev_ovf_d;
      cur_ovf_q  <= cur_ovf_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      halt_q     <= halt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_fib_stream_gen.sv
// Randomised bench: a 32-bit and an 8-bit generator share stimulus and are each
// compared every cycle against a term-list model of the recurrence.
module tb_fib_stream_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] seed0;
  logic [31:0] seed1;
  logic [7:0]  num_terms;
  logic        halt_on_ovf;
  logic        ready;
  logic        busy32, done32, ovf32;
  logic        busy8, done8, ovf8;

  int n_checks = 0;
  int n_pass   = 0;

  fib_stream_gen_if #(.WIDTH(32), .CNT_W(8)) if32 ();
  fib_stream_gen_if #(.WIDTH(8),  .CNT_W(8)) if8 ();

  assign if32.out_ready = ready;
  assign if8.out_ready  = ready;

  fib_stream_gen #(.WIDTH(32), .CNT_W(8)) dut32 (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .num_terms(num_terms), .halt_on_ovf(halt_on_ovf), .out_if(if32),
    .busy(busy32), .done(done32), .overflow(ovf32)
  );

  fib_stream_gen #(.WIDTH(8), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0[7:0]), .seed1(seed1[7:0]),
    .num_terms(num_terms), .halt_on_ovf(halt_on_ovf), .out_if(if8),
    .busy(busy8), .done(done8), .overflow(ovf8)
  );

  // Index 0 = 32-bit instance, index 1 = 8-bit instance.
  logic [63:0] obs_data [2];
  logic [63:0] obs_idx  [2];
  logic        obs_valid[2];
  logic        obs_last [2];
  logic        obs_busy [2];
  logic        obs_done [2];
  logic        obs_ovf  [2];

  assign obs_data[0]  = {32'd0, if32.out_data};
  assign obs_data[1]  = {56'd0, if8.out_data};
  assign obs_idx[0]   = {56'd0, if32.out_index};
  assign obs_idx[1]   = {56'd0, if8.out_index};
  assign obs_valid[0] = if32.out_valid;
  assign obs_valid[1] = if8.out_valid;
  assign obs_last[0]  = if32.out_last;
  assign obs_last[1]  = if8.out_last;
  assign obs_busy[0]  = busy32;
  assign obs_busy[1]  = busy8;
  assign obs_done[0]  = done32;
  assign obs_done[1]  = done8;
  assign obs_ovf[0]   = ovf32;
  assign obs_ovf[1]   = ovf8;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic string nm(input int i, input string what);
    return $sformatf("w%0d_%s", (i == 0) ? 32 : 8, what);
  endfunction

  // Reference: the full term list mod 2^W, first index whose true value wraps,
  // and how many beats the run delivers.
  longint exp_t [2][256];
  int     nbeats[2];
  int     fw    [2];

  task automatic build_model(input logic [31:0] s0, input logic [31:0] s1,
                             input int n, input bit h);
    for (int i = 0; i < 2; i++) begin
      longint m;
      longint raw;
      m = (i == 0) ? 64'h0000_0000_FFFF_FFFF : 64'h0000_0000_0000_00FF;
      exp_t[i][0] = longint'(s0) & m;
      exp_t[i][1] = longint'(s1) & m;
      fw[i] = 1000;
      for (int k = 2; k < n; k++) begin
        raw = exp_t[i][k-2] + exp_t[i][k-1];
        if (raw > m && fw[i] == 1000) fw[i] = k;
        exp_t[i][k] = raw & m;
      end
      nbeats[i] = (h && fw[i] < n) ? fw[i] : n;
    end
  endtask

  task automatic run_case(input logic [31:0] s0, input logic [31:0] s1, input int n,
                          input bit h, input bit rand_ready, input bit spam);
    int pos[2];
    int fin[2];
    int cyc;
    bit exp_ovf;
    build_model(s0, s1, n, h);
    pos = '{0, 0};
    fin = '{0, 0};
    cyc = 0;
    seed0 = s0; seed1 = s1; num_terms = 8'(n); halt_on_ovf = h;
    start = 1'b1;
    ready = 1'b1;
    forever begin
      @(negedge clk);
      start = 1'b0;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (pos[i] < nbeats[i]) begin
          chk(nm(i, "valid"), obs_valid[i], 1);
          chk(nm(i, "data"),  obs_data[i],  exp_t[i][pos[i]]);
          chk(nm(i, "index"), obs_idx[i],   pos[i]);
          chk(nm(i, "last"),  obs_last[i],  (pos[i] == nbeats[i] - 1) ? 1 : 0);
          chk(nm(i, "busy"),  obs_busy[i],  1);
          chk(nm(i, "done"),  obs_done[i],  0);
        end else begin
          fin[i]++;
          chk(nm(i, "valid"), obs_valid[i], 0);
          chk(nm(i, "busy"),  obs_busy[i],  0);
          chk(nm(i, "done"),  obs_done[i],  (fin[i] == 1) ? 1 : 0);
        end
        exp_ovf = (fw[i] < n) && (h ? (pos[i] == nbeats[i]) : (pos[i] > fw[i]));
        chk(nm(i, "overflow"), obs_ovf[i], exp_ovf);
      end
      if (fin[0] >= 2 && fin[1] >= 2) break;
      if (cyc > 2000) begin
        chk("run_timeout", cyc, 0);
        break;
      end
      ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int i = 0; i < 2; i++) begin
        if (pos[i] < nbeats[i] && ready) pos[i]++;
      end
      if (spam && fin[0] == 0 && fin[1] == 0 && $urandom_range(0, 2) == 0) begin
        start       = 1'b1;
        seed0       = $urandom;
        seed1       = $urandom;
        num_terms   = 8'($urandom_range(0, 255));
        halt_on_ovf = 1'($urandom_range(0, 1));
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk(nm(i, {tag, "_valid"}), obs_valid[i], 0);
      chk(nm(i, {tag, "_data"}),  obs_data[i],  0);
      chk(nm(i, {tag, "_index"}), obs_idx[i],   0);
      chk(nm(i, {tag, "_last"}),  obs_last[i],  0);
      chk(nm(i, {tag, "_busy"}),  obs_busy[i],  0);
      chk(nm(i, {tag, "_done"}),  obs_done[i],  0);
      chk(nm(i, {tag, "_ovf"}),   obs_ovf[i],   0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ready = 1'b0;
    seed0 = 32'd0; seed1 = 32'd0; num_terms = 8'd0; halt_on_ovf = 1'b0;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    run_case(32'd0, 32'd1, 10, 1'b0, 1'b0, 1'b0);
    run_case(32'd0, 32'd1, 20, 1'b1, 1'b0, 1'b0);
    run_case(32'd0, 32'd1, 20, 1'b0, 1'b0, 1'b0);
    run_case(32'd2, 32'd1, 6,  1'b0, 1'b1, 1'b1);
    run_case(32'd0, 32'd1, 0,  1'b0, 1'b0, 1'b0);
    run_case(32'd5, 32'd7, 1,  1'b0, 1'b0, 1'b0);
    run_case(32'd0, 32'd1, 255, 1'b0, 1'b0, 1'b0);

    // Abandon a run while index 4 is presented and stalled.
    seed0 = 32'd0; seed1 = 32'd1; num_terms = 8'd10; halt_on_ovf = 1'b0;
    ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("w32_pre_reset_index", obs_idx[0], 4);
    chk("w8_pre_reset_index",  obs_idx[1], 4);
    ready = 1'b0;
    #2 rst = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    chk("w32_no_done_in_reset", obs_done[0], 0);
    chk("w8_no_done_in_reset",  obs_done[1], 0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("w32_no_done_after_reset", obs_done[0], 0);
      chk("w8_no_valid_after_reset", obs_valid[1], 0);
    end
    run_case(32'd0, 32'd1, 10, 1'b0, 1'b1, 1'b0);

    for (int r = 0; r < 24; r++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
      b = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 300));
      run_case(a, b, $urandom_range(0, 40), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
